// File: rtl/pwm_duty_ramp.sv
// Ramps a PWM duty value toward a requested target in STEP increments.
// Duty updates happen only at PWM period boundaries, so the new value starts cleanly at phase 0.
module pwm_duty_ramp #(
  parameter int unsigned STEP         = 8,
  parameter int unsigned HOLD_PERIODS = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] target_i,
  input  logic       target_vld_i,
  output logic       target_rdy_o,
  input  logic       stop_i,
  output logic [7:0] duty_o,
  output logic       period_end_o,
  output logic       busy_o,
  output logic       done_o
);

  typedef enum logic {IDLE, RAMP} state_e;

  state_e      state_q, state_d;
  logic [7:0]  phase_q;
  logic [7:0]  duty_q, duty_d;
  logic [7:0]  target_q, target_d;
  logic [7:0]  hold_q, hold_d;
  logic        done_q, done_d;

  logic        boundary;
  logic        accept;
  logic        hold_last;
  logic [8:0]  up_sum;
  logic signed [9:0] dn_diff;
  logic [7:0]  step_val;

  assign boundary     = (phase_q == 8'd255);
  assign target_rdy_o = (state_q == IDLE) && !stop_i;
  assign accept       = target_vld_i && target_rdy_o;
  assign hold_last    = (hold_q == 8'(HOLD_PERIODS - 1));

  // Extra headroom bits keep the step from wrapping past 255 or below 0.
  assign up_sum  = {1'b0, duty_q} + 9'(STEP);
  assign dn_diff = $signed({2'b00, duty_q}) - $signed(10'(STEP));

  always_comb begin
    step_val = duty_q;
    if (target_q > duty_q) begin
      step_val = (up_sum >= {1'b0, target_q}) ? target_q : up_sum[7:0];
    end else begin
      step_val = (dn_diff <= $signed({2'b00, target_q})) ? target_q : dn_diff[7:0];
    end
  end

  always_comb begin
    state_d  = state_q;
    duty_d   = duty_q;
    target_d = target_q;
    hold_d   = hold_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          target_d = target_i;
          hold_d   = '0;
          if (target_i == duty_q) begin
            done_d = 1'b1;
          end else begin
            state_d = RAMP;
          end
        end
      end
      RAMP: begin
        if (stop_i) begin
          state_d = IDLE;
          hold_d  = '0;
        end else if (boundary) begin
          if (hold_last) begin
            duty_d = step_val;
            hold_d = '0;
            if (step_val == target_q) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            hold_d = hold_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      phase_q  <= '0;
      duty_q   <= '0;
      target_q <= '0;
      hold_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_q + 8'd1;
      duty_q   <= duty_d;
      target_q <= target_d;
      hold_q   <= hold_d;
      done_q   <= done_d;
    end
  end

  assign duty_o       = duty_q;
  assign period_end_o = boundary;
  assign busy_o       = (state_q == RAMP);
  assign done_o       = done_q;

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Scoreboard bench for pwm_duty_ramp: stimulus pushes expected duty steps and done pulses,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_pwm_duty_ramp;
  localparam int STEP_P = 16;
  localparam int HOLD_P = 2;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [7:0] target_i = '0;
  logic       target_vld_i = 1'b0;
  logic       target_rdy_o;
  logic       stop_i = 1'b0;
  logic [7:0] duty_o;
  logic       period_end_o;
  logic       busy_o;
  logic       done_o;

  pwm_duty_ramp #(.STEP(STEP_P), .HOLD_PERIODS(HOLD_P)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .target_i     (target_i),
    .target_vld_i (target_vld_i),
    .target_rdy_o (target_rdy_o),
    .stop_i       (stop_i),
    .duty_o       (duty_o),
    .period_end_o (period_end_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  initial forever #5 clk_i = ~clk_i;

  typedef struct {int val; int edg;} exp_t;
  exp_t exp_duty[$];
  exp_t exp_done[$];

  int total = 0;
  int bad = 0;
  int edge_cnt = 0;
  int tb_phase = 0;
  int model_duty = 0;
  int prev_duty = 0;

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  always @(posedge clk_i) edge_cnt++;

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) tb_phase = 0;
    else tb_phase = (tb_phase + 1) % 256;
  end

  // Monitor: every duty change and done pulse must match the head of its queue.
  always @(negedge clk_i) begin
    exp_t e;
    if (rst_i) begin
      prev_duty = int'(duty_o);
    end else begin
      chk("period_end", int'(period_end_o), int'(tb_phase == 255));
      if (int'(duty_o) != prev_duty) begin
        if (exp_duty.size() == 0) begin
          chk("unexp_duty", int'(duty_o), prev_duty);
        end else begin
          e = exp_duty.pop_front();
          chk("step_val", int'(duty_o), e.val);
          chk("step_edge", edge_cnt, e.edg);
        end
        prev_duty = int'(duty_o);
      end
      if (done_o) begin
        if (exp_done.size() == 0) begin
          chk("unexp_done", int'(done_o), 0);
        end else begin
          e = exp_done.pop_front();
          chk("done_val", int'(duty_o), e.val);
          chk("done_edge", edge_cnt, e.edg);
        end
      end
    end
  end

  // Called at posedge+2. Issues one target and, if push_exp, queues the expected ramp.
  task automatic do_accept(input int t, input bit push_exp, output int first_step_edge);
    int p, acc, cur, k, old;
    exp_t e;
    chk("rdy_before_accept", int'(target_rdy_o), 1);
    target_i = 8'(t);
    target_vld_i = 1'b1;
    p = tb_phase;
    acc = edge_cnt + 1;
    old = model_duty;
    first_step_edge = acc + ((p == 255) ? 256 : 255 - p) + (HOLD_P - 1) * 256;
    if (push_exp) begin
      cur = model_duty;
      k = 0;
      while (cur != t) begin
        if (t > cur) cur = (cur + STEP_P > t) ? t : cur + STEP_P;
        else cur = (cur - STEP_P < t) ? t : cur - STEP_P;
        e.val = cur;
        e.edg = first_step_edge + k * HOLD_P * 256;
        exp_duty.push_back(e);
        k++;
      end
      e.val = t;
      e.edg = (k == 0) ? acc : first_step_edge + (k - 1) * HOLD_P * 256;
      exp_done.push_back(e);
      model_duty = t;
    end
    @(posedge clk_i); #2;
    target_vld_i = 1'b0;
    chk("busy_after_accept", int'(busy_o), int'(t != old));
  endtask

  task automatic wait_idle(input int limit);
    for (int i = 0; i < limit; i++) begin
      @(negedge clk_i);
      if (exp_duty.size() == 0 && exp_done.size() == 0) break;
    end
    chk("drain_duty_q", exp_duty.size(), 0);
    chk("drain_done_q", exp_done.size(), 0);
    exp_duty.delete();
    exp_done.delete();
    @(posedge clk_i); #2;
    chk("busy_idle", int'(busy_o), 0);
    chk("rdy_idle", int'(target_rdy_o), 1);
    chk("duty_idle", int'(duty_o), model_duty);
  endtask

  initial begin
    int fs, n, t;
    repeat (2) @(posedge clk_i);
    #2;
    chk("rst_duty", int'(duty_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_period_end", int'(period_end_o), 0);
    chk("rst_rdy", int'(target_rdy_o), 1);
    #1 rst_i = 1'b0;
    @(posedge clk_i); #2;

    do_accept(64, 1'b1, fs);  wait_idle(7500);
    do_accept(70, 1'b1, fs);  wait_idle(7500);
    do_accept(200, 1'b1, fs); wait_idle(7500);
    do_accept(0, 1'b1, fs);   wait_idle(7500);
    do_accept(0, 1'b1, fs);   wait_idle(50);

    // stop on the boundary that would have stepped 32 -> 48
    do_accept(32, 1'b1, fs);  wait_idle(7500);
    do_accept(64, 1'b0, fs);
    for (int i = 0; i < 2000 && edge_cnt < fs - 1; i++) begin
      @(posedge clk_i); #2;
    end
    chk("stop_align", edge_cnt, fs - 1);
    stop_i = 1'b1;
    target_vld_i = 1'b1;
    target_i = 8'd100;
    #1 chk("stop_rdy", int'(target_rdy_o), 0);
    @(posedge clk_i); #2;
    chk("stop_busy", int'(busy_o), 0);
    chk("stop_duty", int'(duty_o), 32);
    repeat (3) @(posedge clk_i);
    #2 chk("stop_hold_rdy", int'(target_rdy_o), 0);
    stop_i = 1'b0;
    target_vld_i = 1'b0;
    repeat (600) @(posedge clk_i);
    #2;
    chk("stop_after_duty", int'(duty_o), 32);
    chk("stop_after_busy", int'(busy_o), 0);

    for (int i = 0; i < 8; i++) begin
      t = model_duty + int'($urandom_range(0, 128)) - 64;
      if (t < 0) t = 0;
      if (t > 255) t = 255;
      if (i == 3) t = model_duty;
      if (i == 1) begin
        for (int j = 0; j < 300 && tb_phase != 255; j++) begin
          @(posedge clk_i); #2;
        end
      end else begin
        repeat ($urandom_range(0, 300)) @(posedge clk_i);
        #2;
      end
      do_accept(t, 1'b1, fs);
      wait_idle(7500);
    end

    // asynchronous reset in the middle of a ramp
    do_accept((model_duty > 127) ? 0 : 255, 1'b1, fs);
    repeat (700) @(posedge clk_i);
    #1 rst_i = 1'b1;
    #1;
    chk("arst_duty", int'(duty_o), 0);
    chk("arst_busy", int'(busy_o), 0);
    chk("arst_done", int'(done_o), 0);
    chk("arst_period_end", int'(period_end_o), 0);
    chk("arst_rdy", int'(target_rdy_o), 1);
    exp_duty.delete();
    exp_done.delete();
    model_duty = 0;
    repeat (3) @(posedge clk_i);
    #3 rst_i = 1'b0;
    n = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_i);
      n++;
      if (period_end_o) break;
    end
    chk("first_period_end_cycles", n, 256);
    repeat (600) @(posedge clk_i);
    #2;
    chk("post_rst_duty", int'(duty_o), 0);
    chk("post_rst_busy", int'(busy_o), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
